axi_lite_mem_master: RTL and testbench



---
 rtl/axi_lite_mem_master.sv | 189 ++++++++++++++++++
 tb/tb_axi_lite_mem_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_master.sv
// Core-side AXI-lite initiator: turns one blocking core memory request into a single
// AXI-lite read or write transaction and returns data plus a one-cycle completion pulse.
module axi_lite_mem_master #(
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ADDR_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     mem_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     mem_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   mem_wmask,
  input  logic                              mem_wen,
  input  logic                              mem_ren,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     mem_rdata,
  output logic                              mem_valid,
  output logic                              mem_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_awaddr,
  output logic [2:0]                        m_awprot,
  output logic                              m_awvalid,
  input  logic                              m_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                              m_wvalid,
  input  logic                              m_wready,
  input  logic [1:0]                        m_bresp,
  input  logic                              m_bvalid,
  output logic                              m_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_araddr,
  output logic [2:0]                        m_arprot,
  output logic                              m_arvalid,
  input  logic                              m_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                        m_rresp,
  input  logic                              m_rvalid,
  output logic                              m_rready
);
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_W_RESP = 3'd2,
    S_R_ADDR = 3'd3,
    S_R_DATA = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;

  // State and output register bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (mem_wen) begin
          awaddr_d  = mem_addr;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wmask;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WRITE;
        end else if (mem_ren) begin
          araddr_d  = mem_addr;
          arvalid_d = 1'b1;
          state_d   = S_R_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        // Each valid retires independently; B opens only once both have handshaken.
        awvalid_d = awvalid_q & ~m_awready;
        wvalid_d  = wvalid_q & ~m_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_W_RESP;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_W_RESP: begin
        if (m_bvalid) begin
          bready_d = 1'b0;
          err_d    = (m_bresp != 2'b00);
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_W_RESP;
        end
      end
      S_R_ADDR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R_DATA;
        end else begin
          state_d = S_R_ADDR;
        end
      end
      S_R_DATA: begin
        if (m_rvalid) begin
          rdata_d  = m_rdata;
          err_d    = (m_rresp != 2'b00);
          rready_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_R_DATA;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_rdata = rdata_q;
  assign mem_valid = valid_q;
  assign mem_err   = err_q;
  assign m_awaddr  = awaddr_q;
  assign m_awprot  = 3'b000;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_araddr  = araddr_q;
  assign m_arprot  = 3'b000;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Self-checking bench: delay-programmable AXI-lite slave plus a latency/value model
// derived from the transaction rules; directed test-plan cases then random traffic.
module tb_axi_lite_mem_master;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        mem_wen, mem_ren, mem_valid, mem_err;
  logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  axi_lite_mem_master #(.C_M_AXI_DATA_WIDTH(64), .C_M_AXI_ADDR_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_err(mem_err),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Slave programming for the current transaction and what it observed
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
  logic [63:0] r_data = 64'd0;
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  int          aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc, early_b, early_r;
  logic [63:0] aw_addr_seen, w_data_seen, ar_addr_seen;
  logic [7:0]  w_strb_seen;
  logic [63:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin : aw_slave
    int cnt;
    cnt = 0;
    m_awready = 1'b0;
    forever begin
      @(negedge clk);
      m_awready = 1'b0;
      if (m_awvalid) begin
        aw_cyc++;
        if (cnt == aw_dly) begin
          m_awready = 1'b1; aw_hs++; aw_addr_seen = m_awaddr; cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : w_slave
    int cnt;
    cnt = 0;
    m_wready = 1'b0;
    forever begin
      @(negedge clk);
      m_wready = 1'b0;
      if (m_wvalid) begin
        w_cyc++;
        if (cnt == w_dly) begin
          m_wready = 1'b1; w_hs++; w_data_seen = m_wdata; w_strb_seen = m_wstrb; cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : b_slave
    int cnt;
    cnt = 0;
    m_bvalid = 1'b0;
    m_bresp  = 2'b11;
    forever begin
      @(negedge clk);
      m_bvalid = 1'b0;
      m_bresp  = 2'b11;
      if (m_bready) begin
        b_cyc++;
        if (aw_hs != 1 || w_hs != 1) early_b++;
        if (cnt == b_dly) begin
          m_bvalid = 1'b1; m_bresp = b_resp; b_hs++; cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : ar_slave
    int cnt;
    cnt = 0;
    m_arready = 1'b0;
    forever begin
      @(negedge clk);
      m_arready = 1'b0;
      if (m_arvalid) begin
        ar_cyc++;
        if (cnt == ar_dly) begin
          m_arready = 1'b1; ar_hs++; ar_addr_seen = m_araddr; cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : r_slave
    int cnt;
    cnt = 0;
    m_rvalid = 1'b0;
    m_rresp  = 2'b11;
    m_rdata  = 64'd0;
    forever begin
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rresp  = 2'b11;
      m_rdata  = {$urandom, $urandom};
      if (m_rready) begin
        r_cyc++;
        if (ar_hs != 1) early_r++;
        if (cnt == r_dly) begin
          m_rvalid = 1'b1; m_rresp = r_resp; m_rdata = r_data; r_hs++; cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Issue one request from IDLE (called at negedge+1) and check it against the model.
  task automatic do_txn(input string tag, input logic wen, input logic ren,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wmask,
                        input int daw, input int dw, input int db, input int dar, input int dr,
                        input logic [1:0] resp, input logic [63:0] rdat, input bit hold);
    int lat, exp_lat;
    aw_dly = daw; w_dly = dw; b_dly = db; ar_dly = dar; r_dly = dr;
    b_resp = resp; r_resp = resp; r_data = rdat;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    aw_cyc = 0; w_cyc = 0; b_cyc = 0; ar_cyc = 0; r_cyc = 0; early_b = 0; early_r = 0;
    mem_wen = wen; mem_ren = ren; mem_addr = addr; mem_wdata = wdata; mem_wmask = wmask;
    exp_lat = wen ? 3 + ((daw > dw) ? daw : dw) + db : 3 + dar + dr;
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
      if (!hold && !mem_valid) begin
        mem_wen = 1'b0; mem_ren = 1'b0;
        mem_addr = {$urandom, $urandom}; mem_wdata = {$urandom, $urandom}; mem_wmask = 8'($urandom);
      end
    end while (!mem_valid && lat < 100);
    mem_wen = 1'b0;
    mem_ren = hold ? ren : 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " err"}, {63'd0, mem_err}, {63'd0, resp != 2'b00});
    if (wen) begin
      chk({tag, " aw_hs"}, 64'(aw_hs), 64'd1);
      chk({tag, " w_hs"}, 64'(w_hs), 64'd1);
      chk({tag, " ar_hs"}, 64'(ar_hs), 64'd0);
      chk({tag, " awaddr"}, aw_addr_seen, addr);
      chk({tag, " wdata"}, w_data_seen, wdata);
      chk({tag, " wstrb"}, {56'd0, w_strb_seen}, {56'd0, wmask});
      chk({tag, " awvalid_cyc"}, 64'(aw_cyc), 64'(daw + 1));
      chk({tag, " wvalid_cyc"}, 64'(w_cyc), 64'(dw + 1));
      chk({tag, " bready_cyc"}, 64'(b_cyc), 64'(db + 1));
      chk({tag, " early_bready"}, 64'(early_b), 64'd0);
      chk({tag, " rdata_hold"}, mem_rdata, last_rdata);
    end else begin
      chk({tag, " ar_hs"}, 64'(ar_hs), 64'd1);
      chk({tag, " aw_hs"}, 64'(aw_hs), 64'd0);
      chk({tag, " araddr"}, ar_addr_seen, addr);
      chk({tag, " arvalid_cyc"}, 64'(ar_cyc), 64'(dar + 1));
      chk({tag, " rready_cyc"}, 64'(r_cyc), 64'(dr + 1));
      chk({tag, " early_rready"}, 64'(early_r), 64'd0);
      chk({tag, " rdata"}, mem_rdata, rdat);
      last_rdata = rdat;
    end
    @(negedge clk); #1;
    chk({tag, " valid_pulse"}, {63'd0, mem_valid}, 64'd0);
  endtask

  initial begin
    int waits;
    logic w;
    rst = 1'b1;
    mem_wen = 1'b0; mem_ren = 1'b0; mem_addr = 64'd0; mem_wdata = 64'd0; mem_wmask = 8'd0;
    last_rdata = 64'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst mem_err", {63'd0, mem_err}, 64'd0);
    chk("rst valids", {59'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
    chk("rst mem_rdata", mem_rdata, 64'd0);
    chk("rst awaddr", m_awaddr, 64'd0);
    chk("rst araddr", m_araddr, 64'd0);
    chk("rst wdata", m_wdata, 64'd0);
    chk("rst wstrb", {56'd0, m_wstrb}, 64'd0);
    chk("prot", {58'd0, m_awprot, m_arprot}, 64'd0);
    rst = 1'b0;

    do_txn("zw_write", 1'b1, 1'b0, 64'h80, 64'h1122334455667788, 8'hFF, 0, 0, 0, 0, 0, 2'b00, 64'd0, 1'b0);
    do_txn("stagger", 1'b1, 1'b0, 64'h88, 64'hA5A5_5A5A_0F0F_F0F0, 8'h0F, 4, 0, 0, 0, 0, 2'b00, 64'd0, 1'b0);
    do_txn("rd_wait", 1'b0, 1'b1, 64'h1000, 64'd0, 8'd0, 0, 0, 0, 2, 3, 2'b00, 64'hDEADBEEFCAFEF00D, 1'b0);
    do_txn("both_en", 1'b1, 1'b1, 64'h2000, 64'h0123456789ABCDEF, 8'hF0, 1, 2, 1, 0, 0, 2'b00, 64'd0, 1'b1);
    do_txn("after_both", 1'b0, 1'b1, 64'h2000, 64'd0, 8'd0, 0, 0, 0, 1, 0, 2'b00, 64'h5555AAAA33336666, 1'b0);
    do_txn("rd_slverr", 1'b0, 1'b1, 64'h3000, 64'd0, 8'd0, 0, 0, 0, 0, 1, 2'b10, 64'h0BAD0BAD0BAD0BAD, 1'b0);
    do_txn("wr_after_err", 1'b1, 1'b0, 64'h3008, 64'h77, 8'h01, 0, 1, 0, 0, 0, 2'b00, 64'd0, 1'b0);

    // Abort a read while it waits in the data phase
    ar_dly = 0; r_dly = 20; ar_hs = 0; r_cyc = 0;
    mem_ren = 1'b1; mem_addr = 64'h4000;
    @(negedge clk); #1;
    mem_ren = 1'b0;
    waits = 0;
    while (!m_rready && waits < 20) begin
      @(negedge clk); #1;
      waits++;
    end
    chk("mid_rd rready_seen", {63'd0, m_rready}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rd valids", {59'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
    chk("mid_rd mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("mid_rd araddr", m_araddr, 64'd0);
    chk("mid_rd rdata", mem_rdata, 64'd0);
    last_rdata = 64'd0;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    do_txn("post_rst_wr", 1'b1, 1'b0, 64'h4008, 64'hFEEDFACE12345678, 8'h3C, 1, 0, 2, 0, 0, 2'b00, 64'd0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom);
      do_txn($sformatf("rnd%0d", i), w, ~w | 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, {$urandom, $urandom}, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
